memu_stage: RTL and testbench
=============================

// Module: memu_stage
// PURPOSE
//   Memory-access stage of the IITB-RISC-25 16-bit pipeline, directly downstream of exec.
//   Consumes exec results: ALU results pass through, LW/SW/LM/SM beats perform one
//   data-memory access over a req/ack handshake. Drives the register-file writeback
//   port and the MEM-stage forwarding bus.
//   Stalls exec via ex_ready_o while an access is outstanding.
// PARAMETERS
//   DATA_W   16  data and address width
//   RD_W     3   register index width (R0..R7)
//   TIMEOUT  15  max cycles waiting for dmem_ack_i before abort (1..255)
// PORTS
//   clk_i            in   1       clock, rising edge
//   rst_i            in   1       reset, asynchronous, active-high
//   ex_valid_i       in   1       exec result valid
//   ex_ready_o       out  1       stage can accept; transfer = ex_valid_i & ex_ready_o
//   ex_load_i        in   1       beat is a load (LW / one LM beat)
//   ex_store_i       in   1       beat is a store (SW / one SM beat)
//   ex_wb_en_i       in   1       non-memory result writes rd
//   ex_val_i         in   DATA_W  ALU result, or effective address for load/store
//   ex_store_data_i  in   DATA_W  store data
//   ex_rd_idx_i      in   RD_W    destination register
//   ex_pc_i          in   DATA_W  instruction PC, carried for debug
//   dmem_req_o       out  1       memory request
//   dmem_we_o        out  1       1 = write
//   dmem_addr_o      out  DATA_W  address
//   dmem_wdata_o     out  DATA_W  write data
//   dmem_ack_i       in   1       memory completes request this cycle
//   dmem_rdata_i     in   DATA_W  read data, valid with dmem_ack_i
//   wb_valid_o       out  1       one retired beat this cycle
//   wb_en_o          out  1       register-file write enable
//   wb_rd_idx_o      out  RD_W    writeback register
//   wb_val_o         out  DATA_W  writeback value
//   wb_pc_o          out  DATA_W  PC of retired beat
//   fwd_valid_o      out  1       forwarding bus valid (= wb_valid_o & wb_en_o)
//   fwd_rd_o         out  RD_W    forwarding register (= wb_rd_idx_o)
//   fwd_val_o        out  DATA_W  forwarding value (= wb_val_o)
//   mem_err_o        out  1       one-cycle pulse on access timeout
// BEHAVIOUR
//   - Reset: all outputs 0 except ex_ready_o = 1. State IDLE, timeout counter 0.
//     rst_i mid-access drops dmem_req_o immediately. Any in-flight beat is discarded.
//   - FSM states: IDLE, ACCESS.
//   - IDLE: ex_ready_o = 1.
//     - Transfer with neither load nor store: register wb_* next cycle (latency 1).
//       wb_en_o = ex_wb_en_i. Stay IDLE.
//     - Transfer with load or store: latch addr, data, rd, pc and type.
//       Go to ACCESS. ex_ready_o = 0 from the next cycle.
//     - ex_load_i & ex_store_i both high: treat as load.
//   - ACCESS: dmem_req_o = 1, and dmem_we_o, dmem_addr_o, dmem_wdata_o stay stable until ack.
//     ex_ready_o = 0. The counter increments each cycle without ack.
//     - dmem_ack_i: next cycle wb_valid_o = 1.
//       Load: wb_en_o = 1, wb_val_o = dmem_rdata_i captured at ack.
//       Store: wb_en_o = 0.
//       Return to IDLE (ex_ready_o = 1 the same cycle wb_valid_o rises).
//     - Counter reaches TIMEOUT without ack: drop req. Next cycle wb_valid_o = 1,
//       wb_en_o = 0, mem_err_o = 1. Return to IDLE.
//     - Ack on the same cycle the counter reaches TIMEOUT: ack wins, no error.
//   - Minimum memory-op latency: transfer -> req at cycle 1 -> ack at the earliest in cycle 1
//     -> wb at cycle 2.
//   - wb_valid_o, wb_en_o and mem_err_o are single-cycle pulses per beat.
//     wb_val_o, wb_rd_idx_o and wb_pc_o hold their last value otherwise.
//   - A write to R0 is passed through unchanged; the register file decides.
//   - LM/SM are issued by exec as one beat per register. Each beat is independent here.
// TESTING
//   - ALU pass-through: val=0x0002, rd=1, wb_en=1 -> next cycle wb_valid=1, wb_en=1,
//     wb_rd_idx=1, wb_val=0x0002. fwd bus matches. dmem_req never asserted.
//   - LW: addr=0x1004, rd=5; ack 2 cycles after req with rdata=0xBEEF ->
//     req/addr stable until ack, ex_ready_o=0 throughout.
//     wb_val=0xBEEF, wb_rd_idx=5, wb_en=1 one cycle after ack.
//   - SW: addr=0x0208, data=0x5055; ack at the first req cycle -> dmem_we=1,
//     wdata=0x5055. wb_valid=1, wb_en=0. Second op accepted the cycle after.
//   - Back-to-back LM beats rd=7,6,2 with zero-wait ack -> three wb pulses in order,
//     each using its own rdata. No beat is lost while ex_ready_o toggles.
//   - Timeout: LW with ack never asserted -> req held TIMEOUT cycles, then dropped.
//     mem_err_o pulses once, wb_en=0, stage returns to IDLE.
//   - Reset asserted during ACCESS -> dmem_req_o=0 asynchronously, no wb pulse,
//     ex_ready_o=1 after release.

Source files
------------

// File: rtl/memu_stage.sv
// Memory-access stage: passes ALU results through and performs one data-memory access per
// load/store beat over a req/ack handshake, then drives writeback and the MEM forwarding bus.
module memu_stage #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RD_W    = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic              ex_load_i,
    input  logic              ex_store_i,
    input  logic              ex_wb_en_i,
    input  logic [DATA_W-1:0] ex_val_i,
    input  logic [DATA_W-1:0] ex_store_data_i,
    input  logic [RD_W-1:0]   ex_rd_idx_i,
    input  logic [DATA_W-1:0] ex_pc_i,

    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,

    output logic              wb_valid_o,
    output logic              wb_en_o,
    output logic [RD_W-1:0]   wb_rd_idx_o,
    output logic [DATA_W-1:0] wb_val_o,
    output logic [DATA_W-1:0] wb_pc_o,

    output logic              fwd_valid_o,
    output logic [RD_W-1:0]   fwd_rd_o,
    output logic [DATA_W-1:0] fwd_val_o,

    output logic              mem_err_o
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    // Last request cycle: the counter starts at 0 on the first req cycle.
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic              is_load_q, is_load_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0] pc_q, pc_d;

    logic              wb_valid_q, wb_valid_d;
    logic              wb_en_q, wb_en_d;
    logic              mem_err_q, mem_err_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_val_q, wb_val_d;
    logic [DATA_W-1:0] wb_pc_q, wb_pc_d;

    logic              transfer;
    logic              is_mem;

    assign transfer = ex_valid_i & ex_ready_o;
    assign is_mem   = ex_load_i | ex_store_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_load_d  = is_load_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        pc_d       = pc_q;
        wb_valid_d = 1'b0;
        wb_en_d    = 1'b0;
        mem_err_d  = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_val_d   = wb_val_q;
        wb_pc_d    = wb_pc_q;

        ex_ready_o   = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;

        unique case (state_q)
            StIdle: begin
                ex_ready_o = 1'b1;
                cnt_d      = '0;
                if (transfer) begin
                    if (is_mem) begin
                        // Load wins when both type bits are set.
                        is_load_d = ex_load_i;
                        addr_d    = ex_val_i;
                        wdata_d   = ex_store_data_i;
                        rd_d      = ex_rd_idx_i;
                        pc_d      = ex_pc_i;
                        state_d   = StAccess;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_en_d    = ex_wb_en_i;
                        wb_rd_d    = ex_rd_idx_i;
                        wb_val_d   = ex_val_i;
                        wb_pc_d    = ex_pc_i;
                    end
                end
            end
            StAccess: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = ~is_load_q;
                dmem_addr_o  = addr_q;
                dmem_wdata_o = wdata_q;
                if (dmem_ack_i) begin
                    wb_valid_d = 1'b1;
                    wb_en_d    = is_load_q;
                    wb_rd_d    = rd_q;
                    wb_pc_d    = pc_q;
                    if (is_load_q) begin
                        wb_val_d = dmem_rdata_i;
                    end
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    // Abort: retire the beat without a register write and flag the error.
                    wb_valid_d = 1'b1;
                    mem_err_d  = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_pc_d    = pc_q;
                    cnt_d      = '0;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_load_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            pc_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            mem_err_q  <= 1'b0;
            wb_rd_q    <= '0;
            wb_val_q   <= '0;
            wb_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_load_q  <= is_load_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            wb_valid_q <= wb_valid_d;
            wb_en_q    <= wb_en_d;
            mem_err_q  <= mem_err_d;
            wb_rd_q    <= wb_rd_d;
            wb_val_q   <= wb_val_d;
            wb_pc_q    <= wb_pc_d;
        end
    end

    assign wb_valid_o  = wb_valid_q;
    assign wb_en_o     = wb_en_q;
    assign wb_rd_idx_o = wb_rd_q;
    assign wb_val_o    = wb_val_q;
    assign wb_pc_o     = wb_pc_q;
    assign mem_err_o   = mem_err_q;

    assign fwd_valid_o = wb_valid_q & wb_en_q;
    assign fwd_rd_o    = wb_rd_q;
    assign fwd_val_o   = wb_val_q;

endmodule

// File: tb/tb_memu_stage.sv
// Randomized bench for memu_stage: a transaction-level model predicts, per cycle, ready,
// the request window and each retirement; a reset-during-access case follows.
module tb_memu_stage;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_load, ex_store, ex_wb_en;
    logic [15:0] ex_val, ex_store_data, ex_pc;
    logic [2:0]  ex_rd_idx;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_en, fwd_valid, mem_err;
    logic [2:0]  wb_rd_idx, fwd_rd;
    logic [15:0] wb_val, wb_pc, fwd_val;

    always #5 clk = ~clk;

    memu_stage #(.DATA_W(16), .RD_W(3), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_load_i(ex_load),
        .ex_store_i(ex_store), .ex_wb_en_i(ex_wb_en), .ex_val_i(ex_val),
        .ex_store_data_i(ex_store_data), .ex_rd_idx_i(ex_rd_idx), .ex_pc_i(ex_pc),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_wdata_o(dmem_wdata), .dmem_ack_i(dmem_ack), .dmem_rdata_i(dmem_rdata),
        .wb_valid_o(wb_valid), .wb_en_o(wb_en), .wb_rd_idx_o(wb_rd_idx),
        .wb_val_o(wb_val), .wb_pc_o(wb_pc),
        .fwd_valid_o(fwd_valid), .fwd_rd_o(fwd_rd), .fwd_val_o(fwd_val),
        .mem_err_o(mem_err)
    );

    typedef struct {
        bit          en;
        bit          err;
        bit          chk_val;
        logic [2:0]  rd;
        logic [15:0] val;
        logic [15:0] pc;
    } wb_t;

    int n_vec = 0;
    int n_err = 0;

    // Model state: cycle indices are counted in clock periods after reset release.
    int          busy_until = -1;
    int          req_lo = 0;
    int          req_hi = -1;
    int          ack_at = -1;
    bit          cur_load;
    logic [15:0] cur_addr, cur_wdata, ack_data;
    wb_t         exp_wb [int];
    bit          val_known = 1'b1;
    logic [15:0] last_val = '0;
    logic [15:0] last_pc = '0;
    logic [2:0]  last_rd = '0;

    bit          holding = 1'b0;
    bit          h_load, h_store, h_wb;
    logic [15:0] h_val, h_data, h_pc;
    logic [2:0]  h_rd;
    int          beats_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_cycle(input int n);
        wb_t e;
        bit  req_exp;
        req_exp = (n >= req_lo) && (n <= req_hi);
        check("ex_ready", ex_ready, n > busy_until);
        check("dmem_req", dmem_req, req_exp);
        if (req_exp) begin
            check("dmem_we", dmem_we, !cur_load);
            check("dmem_addr", dmem_addr, cur_addr);
            if (!cur_load) check("dmem_wdata", dmem_wdata, cur_wdata);
        end
        if (exp_wb.exists(n)) begin
            e = exp_wb[n];
            exp_wb.delete(n);
            check("wb_valid", wb_valid, 1);
            check("wb_en", wb_en, e.en);
            check("mem_err", mem_err, e.err);
            check("wb_rd_idx", wb_rd_idx, e.rd);
            check("wb_pc", wb_pc, e.pc);
            check("fwd_valid", fwd_valid, e.en);
            check("fwd_rd", fwd_rd, e.rd);
            if (e.chk_val) begin
                check("wb_val", wb_val, e.val);
                check("fwd_val", fwd_val, e.val);
                last_val  = e.val;
                val_known = 1'b1;
            end else begin
                val_known = 1'b0;
            end
            last_rd = e.rd;
            last_pc = e.pc;
        end else begin
            check("wb_valid_idle", wb_valid, 0);
            check("wb_en_idle", wb_en, 0);
            check("mem_err_idle", mem_err, 0);
            check("fwd_valid_idle", fwd_valid, 0);
            check("wb_rd_hold", wb_rd_idx, last_rd);
            check("wb_pc_hold", wb_pc, last_pc);
            if (val_known) check("wb_val_hold", wb_val, last_val);
        end
    endtask

    task automatic drive(input int n, input bit allow_new);
        wb_t e;
        int  sel;
        int  k;
        bit  acked;
        dmem_ack   = (n == ack_at);
        dmem_rdata = dmem_ack ? ack_data : 16'($urandom);
        if (!holding && allow_new && $urandom_range(0, 3) != 0) begin
            sel     = $urandom_range(0, 7);
            h_load  = (sel == 3) || (sel == 4) || (sel == 7);
            h_store = (sel == 5) || (sel == 6) || (sel == 7);
            h_wb    = 1'($urandom);
            h_val   = 16'($urandom);
            h_data  = 16'($urandom);
            h_pc    = 16'($urandom);
            h_rd    = 3'($urandom);
            holding = 1'b1;
            beats_left--;
        end
        ex_valid = holding;
        if (holding) begin
            ex_load = h_load; ex_store = h_store; ex_wb_en = h_wb;
            ex_val = h_val; ex_store_data = h_data; ex_pc = h_pc; ex_rd_idx = h_rd;
        end else begin
            ex_load = 1'($urandom); ex_store = 1'($urandom); ex_wb_en = 1'($urandom);
            ex_val = 16'($urandom); ex_store_data = 16'($urandom);
            ex_pc = 16'($urandom); ex_rd_idx = 3'($urandom);
        end
        if (holding && n > busy_until) begin
            holding = 1'b0;
            e.rd = h_rd;
            e.pc = h_pc;
            if (h_load || h_store) begin
                sel = $urandom_range(0, 9);
                if (sel < 7) begin
                    k = $urandom_range(1, 3); acked = 1'b1;
                end else if (sel == 7) begin
                    k = TIMEOUT; acked = 1'b1;
                end else begin
                    k = TIMEOUT; acked = 1'b0;
                end
                cur_load   = h_load;
                cur_addr   = h_val;
                cur_wdata  = h_data;
                req_lo     = n + 1;
                req_hi     = n + k;
                busy_until = n + k;
                ack_at     = acked ? n + k : -1;
                ack_data   = 16'($urandom);
                e.en       = acked && h_load;
                e.err      = !acked;
                e.chk_val  = acked && h_load;
                e.val      = ack_data;
                exp_wb[n + k + 1] = e;
            end else begin
                e.en      = h_wb;
                e.err     = 1'b0;
                e.chk_val = 1'b1;
                e.val     = h_val;
                exp_wb[n + 1] = e;
            end
        end
    endtask

    initial begin
        bit drained;
        rst = 1'b1;
        ex_valid = 0; ex_load = 0; ex_store = 0; ex_wb_en = 0;
        ex_val = 0; ex_store_data = 0; ex_pc = 0; ex_rd_idx = 0;
        dmem_ack = 0; dmem_rdata = 0;
        repeat (3) @(negedge clk);
        check("rst_ex_ready", ex_ready, 1);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_dmem_addr", dmem_addr, 0);
        check("rst_dmem_wdata", dmem_wdata, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_rd", wb_rd_idx, 0);
        check("rst_wb_val", wb_val, 0);
        check("rst_wb_pc", wb_pc, 0);
        check("rst_fwd_valid", fwd_valid, 0);
        check("rst_fwd_val", fwd_val, 0);
        check("rst_mem_err", mem_err, 0);
        rst = 1'b0;

        beats_left = 400;
        drained = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            check_cycle(n);
            if (beats_left == 0 && !holding && n > busy_until && exp_wb.num() == 0) begin
                drained = 1'b1;
                break;
            end
            drive(n, beats_left > 0);
        end
        check("drain_done", drained, 1);

        // Load issued, then reset while the request is outstanding.
        ex_valid = 1; ex_load = 1; ex_store = 0; ex_val = 16'h1004; ex_rd_idx = 3'd5;
        dmem_ack = 0;
        @(negedge clk);
        ex_valid = 0;
        check("rst_mid_req_before", dmem_req, 1);
        @(negedge clk);
        check("rst_mid_req_held", dmem_req, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_req_drop", dmem_req, 0);
        check("rst_mid_ready", ex_ready, 1);
        check("rst_mid_wb_valid", wb_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_wb_valid", wb_valid, 0);
            check("post_rst_ready", ex_ready, 1);
            check("post_rst_req", dmem_req, 0);
            check("post_rst_err", mem_err, 0);
            check("post_rst_wb_val", wb_val, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
